jk_updown_counter: RTL and testbench
====================================

// Module: jk_updown_counter
// PURPOSE
//   Synchronous N-bit up/down counter built from per-bit JK flip-flop cells
//   (J/K toggle logic, no behavioural q+1). It consumes the JK cell's
//   hold/reset/set/toggle behaviour as the next stage of the sequential lab
//   chain and produces a count, a terminal-count flag and a sticky overflow
//   flag for downstream dividers and sequencers.
// PARAMETERS
//   WIDTH      4      counter width in bits (>=2)
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   en     in   1      count enable
//   up     in   1      direction: 1 = increment, 0 = decrement
//   load   in   1      parallel load strobe
//   d      in   WIDTH  parallel load value
//   q      out  WIDTH  current count (JK cell outputs)
//   qn     out  WIDTH  complement of q
//   tc     out  1      terminal count, combinational
//   ovf    out  1      sticky wrap flag, registered
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low.
//   - Reset (rst_n=0 at clk edge): q=0, qn=all ones, ovf=0. tc follows its
//     equation from q=0.
//   - Priority at each clk edge: reset > load > en count > hold.
//   - Bit cell: q_next = J&~q | ~K&q. JK=00 hold, 01 reset, 10 set, 11 toggle.
//   - Load: J[i]=d[i], K[i]=~d[i]. Result is q=d after 1 cycle. Load clears
//     ovf. Load ignores en and up.
//   - Count up (en=1, up=1): J[i]=K[i]=&q[i-1:0]. Bit 0 always toggles.
//   - Count down (en=1, up=0): J[i]=K[i]=&qn[i-1:0]. Bit 0 always toggles.
//   - Hold (en=0, load=0): J=K=0 for all bits. q unchanged.
//   - Latency: the new q is visible 1 cycle after the qualifying edge.
//     No combinational path from d to q.
//   - Wrap-around: up from all ones gives 0. Down from 0 gives all ones.
//     Both wrap directions are legal.
//   - tc = en & ~load & (up ? &q : ~|q). It is high in the cycle before a
//     wrap.
//   - ovf is set at the edge where a wrap occurs and stays set until reset
//     or load. If a load and a wrap condition occur together, load wins and
//     ovf is cleared.
//   - A change of up between cycles takes effect at the next edge. There is
//     no pipeline state to flush.
//   - Reset mid-count: q=0 at that edge regardless of en, load and up.
//     Counting resumes on the first edge with rst_n=1.
//   - qn is always ~q. It is never equal to q, including during reset.
//   - X on en, up or load while rst_n=0 must not propagate to q.
// TESTING
//   1. rst_n=0 for 2 clk, en=1, load=1 -> q=0000, qn=1111, ovf=0, tc=0
//      (up=1).
//   2. rst_n=1, en=1, up=1 for 17 clk -> q steps 1..15, then 0, then 1.
//      tc=1 only while q=1111. ovf=1 from the wrap edge onward.
//   3. load=1, d=0101 -> q=0101 next cycle, ovf=0. Then up=0, en=1 for
//      6 clk -> 4,3,2,1,0,1111. tc=1 while q=0000. ovf=1 after the wrap.
//   4. q=0111, en=0, up toggling for 4 clk -> q stays 0111, tc=0,
//      ovf unchanged.
//   5. q=1111, up=1, en=1, load=1, d=0011 in the same cycle -> q=0011,
//      ovf=0 (load beats wrap).
//   6. Mid-count rst_n=0 for 1 clk at q=1010 -> q=0000, ovf=0. Next edge
//      with en=1, up=1 -> q=0001.

Source files
------------

// File: rtl/jk_updown_counter.sv
// -----------------------------------------------------------------------------
// jk_updown_counter
//   Synchronous WIDTH-bit up/down counter assembled from per-bit JK flip-flop
//   cells. The next count comes only from J/K toggle logic driving each cell;
//   there is no behavioural q+1 / q-1 adder.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   en     in   1      count enable
//   up     in   1      direction: 1 = increment, 0 = decrement
//   load   in   1      parallel load strobe (beats en/up)
//   d      in   WIDTH  parallel load value
//   q      out  WIDTH  current count (JK cell outputs)
//   qn     out  WIDTH  complement of q (JK cell outputs)
//   tc     out  1      terminal count, combinational (high the cycle before a wrap)
//   ovf    out  1      sticky wrap flag, registered; cleared by reset or load
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// jk_updown_counter_cell
//   Single JK flip-flop with synchronous active-low reset.
//   JK = 00 hold, 01 reset, 10 set, 11 toggle.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset (q -> 0)
//   i_j    in   1   J input
//   i_k    in   1   K input
//   o_q    out  1   stored bit
//   o_qn   out  1   complement of stored bit
// -----------------------------------------------------------------------------
module jk_updown_counter_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q,
  output logic o_qn
);

  logic r_q;

  // Reset is tested first so unknown J/K during reset never reach r_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= (i_j & ~r_q) | (~i_k & r_q);
    end
  end

  assign o_q  = r_q;
  assign o_qn = ~r_q;

endmodule


module jk_updown_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_up_all;   // w_up_all[i] = &q[i-1:0]  (1 for bit 0)
  logic [WIDTH-1:0] w_dn_all;   // w_dn_all[i] = &qn[i-1:0] (1 for bit 0)
  logic             w_wrap;

  // Running AND chains: a bit toggles when every lower bit is 1 (counting up)
  // or every lower bit is 0 (counting down).
  always_comb begin
    logic up_run;
    logic dn_run;
    w_up_all = '0;
    w_dn_all = '0;
    up_run   = 1'b1;
    dn_run   = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_up_all[i] = up_run;
      w_dn_all[i] = dn_run;
      up_run      = up_run & w_q[i];
      dn_run      = dn_run & w_qn[i];
    end
  end

  // J/K steering: load (set/reset each bit to d) > count (toggle) > hold.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (load) begin
      w_j = d;
      w_k = ~d;
    end else if (en) begin
      w_j = up ? w_up_all : w_dn_all;
      w_k = up ? w_up_all : w_dn_all;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_updown_counter_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .i_j   (w_j[g]),
      .i_k   (w_k[g]),
      .o_q   (w_q[g]),
      .o_qn  (w_qn[g])
    );
  end

  // Terminal count is exactly the condition under which the next edge wraps.
  assign w_wrap = en & ~load & (up ? (&w_q) : ~(|w_q));
  assign tc     = w_wrap;

  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (load) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end
  end

  assign q   = w_q;
  assign qn  = w_qn;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;
  logic         ovf;

  typedef struct {
    logic [W-1:0] q;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_q;
  logic         m_ovf;
  logic         exp_tc;
  int           passed;
  int           total;

  jk_updown_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .qn    (qn),
    .tc    (tc),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs on the falling edge, compute expected tc from
  // the current model state, advance the arithmetic reference model and queue
  // the expected post-edge state.
  task automatic apply(input logic r, input logic e, input logic u,
                       input logic l, input logic [W-1:0] dv);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; up = u; load = l; d = dv;
    exp_tc = e & ~l & (u ? (m_q == 4'hF) : (m_q == 4'h0));
    if (!r) begin
      m_q = '0; m_ovf = 1'b0;
    end else if (l) begin
      m_q = dv; m_ovf = 1'b0;
    end else if (e) begin
      if (u) begin
        if (m_q == 4'hF) m_ovf = 1'b1;
        m_q = m_q + 4'd1;
      end else begin
        if (m_q == 4'h0) m_ovf = 1'b1;
        m_q = m_q - 4'd1;
      end
    end
    x.q = m_q; x.ovf = m_ovf;
    sb.push_back(x);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) apply(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
      else       apply(1'b0, 1'bx, 1'bx, 1'bx, 4'hA);
      if (!$isunknown(exp_tc)) begin
        total++;
        if (tc !== exp_tc) $display("FAIL reset_tc: got %b want %b", tc, exp_tc);
        else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL reset_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL reset_state: got q=%b qn=%b ovf=%b want q=%b qn=%b ovf=%b",
                   q, qn, ovf, x.q, ~x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  task automatic test_count_up();
    exp_t x;
    for (int i = 0; i < 17; i++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      total++;
      if (tc !== exp_tc) $display("FAIL up_tc[%0d]: got %b want %b", i, tc, exp_tc);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL up_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL up_state[%0d]: got q=%b qn=%b ovf=%b want q=%b qn=%b ovf=%b",
                   i, q, qn, ovf, x.q, ~x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  // Load 0101, count down through the wrap, then keep counting down to 0111
  // so the hold test starts with ovf set.
  task automatic test_load_count_down();
    exp_t x;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);
      else        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      total++;
      if (tc !== exp_tc) $display("FAIL down_tc[%0d]: got %b want %b", i, tc, exp_tc);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL down_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL down_state[%0d]: got q=%b qn=%b ovf=%b want q=%b qn=%b ovf=%b",
                   i, q, qn, ovf, x.q, ~x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  task automatic test_hold();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, i[0], 1'b0, 4'h0);
      total++;
      if (tc !== 1'b0) $display("FAIL hold_tc[%0d]: got %b want 0", i, tc);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL hold_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== 4'h7 || q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL hold_state[%0d]: got q=%b ovf=%b want q=%b ovf=%b",
                   i, q, ovf, x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  // Reach 1111 by loading it, then load 0011 while a wrap would also occur.
  task automatic test_load_beats_wrap();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) apply(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
      else        apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h3);
      total++;
      if (tc !== 1'b0) $display("FAIL lw_tc[%0d]: got %b want 0", i, tc);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL lw_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL lw_state[%0d]: got q=%b ovf=%b want q=%b ovf=%b",
                   i, q, ovf, x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  // Load 1001, count to 1010, reset mid-count, then resume counting.
  task automatic test_mid_reset();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       apply(1'b1, 1'b0, 1'b0, 1'b1, 4'h9);
        1:       apply(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        2:       apply(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        default: apply(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      endcase
      total++;
      if (tc !== exp_tc) $display("FAIL mr_tc[%0d]: got %b want %b", i, tc, exp_tc);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL mr_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL mr_state[%0d]: got q=%b ovf=%b want q=%b ovf=%b",
                   i, q, ovf, x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic r, e, u, l;
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 19) != 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1);
      l = ($urandom_range(0, 7) == 0);
      apply(r, e, u, l, 4'($urandom_range(0, 15)));
      total++;
      if (tc !== exp_tc) $display("FAIL b2b_tc[%0d]: got %b want %b", i, tc, exp_tc);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL b2b_sb: queue empty");
      else begin
        x = sb.pop_front();
        if (q !== x.q || qn !== ~x.q || ovf !== x.ovf)
          $display("FAIL b2b_state[%0d]: got q=%b qn=%b ovf=%b want q=%b ovf=%b",
                   i, q, qn, ovf, x.q, x.ovf);
        else passed++;
      end
    end
  endtask

  initial begin
    passed = 0; total = 0;
    m_q = '0; m_ovf = 1'b0; exp_tc = 1'b0;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    test_reset();
    test_count_up();
    test_load_count_down();
    test_hold();
    test_load_beats_wrap();
    test_mid_reset();
    test_back_to_back();
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
